sobel_window_sequencer: RTL and testbench
=========================================

// Module: sobel_window_sequencer
// PURPOSE
//  Producer/driver side of the per-pair Sobels difference unit in the Harris path.
//  Accepts one 3x3 pixel window and issues its 8 centre/neighbour pairs to the unit, one at a time.
//  Chains each returned Eout into the next inE and emits the final minimum score with a corner flag.
//  The score is the minimum squared difference.
//  Sits between the window buffer (upstream) and the corner-map writer (downstream).
// PARAMETERS
//  PIX_W    8       pixel width; must match the unit's inCenter/inTarget
//  E_W      14      energy width; must match the unit's inE/Eout
//  TIMEOUT  16      max cycles to wait for any single sob_q edge before aborting the window
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  win_valid    in   1         window present
//  win_ready    out  1         window accepted when valid&ready
//  win_pix      in   9*PIX_W   pixel k (row-major, k=0..8) at [PIX_W*k +: PIX_W]; centre is k=4
//  thr          in   E_W       corner threshold, sampled at window accept
//  sob_start    out  1         drives unit start
//  sob_center   out  PIX_W     drives unit inCenter
//  sob_target   out  PIX_W     drives unit inTarget
//  sob_e        out  E_W       drives unit inE (running minimum)
//  sob_q        in   1         unit Q
//  sob_eout     in   E_W       unit Eout
//  score_valid  out  1         result present
//  score_ready  in   1         downstream accepts result
//  score        out  E_W       minimum energy for the window
//  corner       out  1         score > thr (strict)
//  timeout_err  out  1         sticky; set on abort, cleared at next window accept
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0, except win_ready=1 and sob_e=E_INIT (all ones).
//  All outputs are registered. The unit acts only on alternate clocks and holds Q/Eout between actions.
//  FSM states: IDLE, ISSUE, CAPTURE, DRAIN, DONE.
//   IDLE:    win_ready=1. On win_valid:
//            - latch window and thr; clear timeout_err;
//            - nbr=0; sob_e=E_INIT; go to ISSUE.
//   ISSUE:   sob_start=1; sob_center=pix[4]; sob_target=pix[NBR_IDX[nbr]].
//            Wait for sob_q=1, then go to CAPTURE.
//   CAPTURE: latch sob_eout into sob_e (running min); sob_start=0; go to DRAIN.
//   DRAIN:   wait for sob_q=0 (this prevents stale Q from being taken for the next pair).
//            Then, if nbr==7, go to DONE; else nbr++ and go to ISSUE.
//   DONE:    score_valid=1; score=sob_e; corner=(sob_e>thr).
//            Hold stable until score_ready, then go to IDLE.
//  NBR_IDX = {0,1,2,3,5,6,7,8}. Pixels are unsigned; the squaring and min are done by the unit.
//  The sequencer does not re-min: it takes sob_eout verbatim.
//  Wait timer: counts cycles in ISSUE and in DRAIN; restarts on each state entry.
//   If it reaches TIMEOUT:
//   - set timeout_err; force score=E_INIT and corner=0;
//   - drop sob_start; go to DONE.
//  Latency: a pair needs at most 8 clocks with a healthy unit.
//   Window accept -> score_valid is at most 66 clocks.
//  Backpressure: win_ready=0 outside IDLE. score holds while valid&!ready.
//  No window is accepted in the cycle score handshakes; IDLE is entered first.
//  Reset mid-window: window is dropped, no score is emitted, and sob_start drops immediately.
// STRUCTURE
//  Shared package sobel_pkg holds:
//   - PIX_W, E_W, E_INIT;
//   - seq_state_t enum;
//   - NBR_IDX constant array;
//   - CENTER_IDX=4.
//  One natural sub-module, sobel_wait_timer: a load/enable counter with a terminal flag, parameterised by TIMEOUT.
//  Everything else stays inline.
// TESTING
//  Bench pairs the DUT with a behavioural unit model: acts every other clk; Eout = min((t-c)^2 truncated to E_W, inE).
//  1. All nine pixels = 50, thr=0 -> sob_start pulses 8 times; score=0, corner=0, timeout_err=0.
//  2. Centre=100; neighbours 110,120,103,130,140,150,160,170; thr=5 -> score=9, corner=1.
//     Target sequence seen on sob_target: 110,120,103,130,140,150,160,170.
//  3. Scenario 2 with score_ready held low 20 clks -> score/corner stable and win_ready=0 throughout.
//     The next window is accepted only after the score handshake.
//  4. Unit model mutes Q on pair 3 -> after 16 clks in ISSUE: timeout_err=1, score=14'h3FFF, corner=0.
//     The next window clears timeout_err.
//  5. rst_n low for 1 clk during pair 5 -> all outputs return to reset values in that cycle.
//     No score_valid for the aborted window; a following window completes normally.
//  6. Back-to-back windows with win_valid held high and score_ready=1 -> scores in order.
//     Each window has exactly 8 start/Q handshakes; Q must be low before every new start.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencer and its helpers.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int E_W        = 14;
  localparam int CENTER_IDX = 4;
  localparam int NBR_CNT    = 8;

  localparam logic [E_W-1:0] E_INIT = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DRAIN,
    DONE
  } seq_state_t;

  // Row-major neighbour order around the centre pixel (index 4 skipped).
  localparam logic [3:0] NBR_IDX [NBR_CNT] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8
  };

endpackage

// File: rtl/sobel_wait_timer.sv
// Load/enable wait counter; tc_o fires on the TIMEOUT-th enabled cycle after a load.
module sobel_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Feeds the 8 centre/neighbour pairs of a 3x3 window to the Sobel difference unit,
// chains the running minimum through inE and reports the final score with a corner flag.
module sobel_window_sequencer #(
  parameter int PIX_W   = sobel_pkg::PIX_W,
  parameter int E_W     = sobel_pkg::E_W,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic [9*PIX_W-1:0] win_pix,
  input  logic [E_W-1:0]     thr,
  output logic               sob_start,
  output logic [PIX_W-1:0]   sob_center,
  output logic [PIX_W-1:0]   sob_target,
  output logic [E_W-1:0]     sob_e,
  input  logic               sob_q,
  input  logic [E_W-1:0]     sob_eout,
  output logic               score_valid,
  input  logic               score_ready,
  output logic [E_W-1:0]     score,
  output logic               corner,
  output logic               timeout_err
);

  import sobel_pkg::*;

  seq_state_t       state_q;
  logic [PIX_W-1:0] pix_q [9];
  logic [PIX_W-1:0] win_pix_a [9];
  logic [E_W-1:0]   thr_q;
  logic [2:0]       nbr_q;
  logic             win_ready_q;
  logic             sob_start_q;
  logic [PIX_W-1:0] sob_center_q;
  logic [PIX_W-1:0] sob_target_q;
  logic [E_W-1:0]   sob_e_q;
  logic             score_valid_q;
  logic [E_W-1:0]   score_q;
  logic             corner_q;
  logic             timeout_err_q;

  logic tmr_load;
  logic tmr_en;
  logic tmr_tc;

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      win_pix_a[k] = win_pix[PIX_W*k +: PIX_W];
    end
  end

  // Timer restarts on every entry into ISSUE or DRAIN, including DRAIN->ISSUE.
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE:    tmr_load = win_valid;
      ISSUE:   tmr_en   = 1'b1;
      CAPTURE: tmr_load = 1'b1;
      DRAIN: begin
        tmr_en   = 1'b1;
        tmr_load = !sob_q && (nbr_q != 3'd7);
      end
      default: ;
    endcase
  end

  sobel_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(tmr_load),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pix_q         <= '{default: '0};
      thr_q         <= '0;
      nbr_q         <= '0;
      win_ready_q   <= 1'b1;
      sob_start_q   <= 1'b0;
      sob_center_q  <= '0;
      sob_target_q  <= '0;
      sob_e_q       <= '1;
      score_valid_q <= 1'b0;
      score_q       <= '0;
      corner_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            pix_q         <= win_pix_a;
            thr_q         <= thr;
            timeout_err_q <= 1'b0;
            nbr_q         <= '0;
            sob_e_q       <= '1;
            sob_start_q   <= 1'b1;
            sob_center_q  <= win_pix_a[CENTER_IDX];
            sob_target_q  <= win_pix_a[NBR_IDX[0]];
            win_ready_q   <= 1'b0;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (sob_q) begin
            sob_start_q <= 1'b0;
            state_q     <= CAPTURE;
          end else if (tmr_tc) begin
            timeout_err_q <= 1'b1;
            score_q       <= '1;
            corner_q      <= 1'b0;
            score_valid_q <= 1'b1;
            sob_start_q   <= 1'b0;
            state_q       <= DONE;
          end
        end
        CAPTURE: begin
          sob_e_q <= sob_eout;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (!sob_q) begin
            if (nbr_q == 3'd7) begin
              score_valid_q <= 1'b1;
              score_q       <= sob_e_q;
              corner_q      <= (sob_e_q > thr_q);
              state_q       <= DONE;
            end else begin
              nbr_q        <= nbr_q + 3'd1;
              sob_start_q  <= 1'b1;
              sob_center_q <= pix_q[CENTER_IDX];
              sob_target_q <= pix_q[NBR_IDX[nbr_q + 3'd1]];
              state_q      <= ISSUE;
            end
          end else if (tmr_tc) begin
            timeout_err_q <= 1'b1;
            score_q       <= '1;
            corner_q      <= 1'b0;
            score_valid_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          if (score_ready) begin
            score_valid_q <= 1'b0;
            win_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win_ready   = win_ready_q;
  assign sob_start   = sob_start_q;
  assign sob_center  = sob_center_q;
  assign sob_target  = sob_target_q;
  assign sob_e       = sob_e_q;
  assign score_valid = score_valid_q;
  assign score       = score_q;
  assign corner      = corner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench for sobel_window_sequencer paired with a behavioural difference unit.
module tb_sobel_window_sequencer;

  localparam int PW = 8;
  localparam int EW = 14;

  typedef struct {
    logic [EW-1:0] score;
    logic          corner;
    logic          terr;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            win_valid;
  logic            win_ready;
  logic [9*PW-1:0] win_pix;
  logic [EW-1:0]   thr;
  logic            sob_start;
  logic [PW-1:0]   sob_center;
  logic [PW-1:0]   sob_target;
  logic [EW-1:0]   sob_e;
  logic            sob_q;
  logic [EW-1:0]   sob_eout;
  logic            score_valid;
  logic            score_ready;
  logic [EW-1:0]   score;
  logic            corner;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [7:0]  tgt_q[$];

  logic        u_phase;
  logic        mute_en;
  logic [7:0]  mute_target;
  logic        start_prev;

  logic [7:0] W_FLAT [9] = '{default: 8'd50};
  logic [7:0] W_S2   [9] = '{8'd110, 8'd120, 8'd103, 8'd130, 8'd100, 8'd140, 8'd150, 8'd160, 8'd170};
  logic [7:0] W_A    [9] = '{8'd20, 8'd30, 8'd40, 8'd50, 8'd10, 8'd60, 8'd70, 8'd80, 8'd15};
  logic [7:0] W_B    [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] W_C    [9] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
  int         NB     [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  sobel_window_sequencer #(
    .PIX_W  (PW),
    .E_W    (EW),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_pix    (win_pix),
    .thr        (thr),
    .sob_start  (sob_start),
    .sob_center (sob_center),
    .sob_target (sob_target),
    .sob_e      (sob_e),
    .sob_q      (sob_q),
    .sob_eout   (sob_eout),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .score      (score),
    .corner     (corner),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] unit_e(input logic [7:0] c, input logic [7:0] t,
                                           input logic [EW-1:0] e);
    int d;
    logic [EW-1:0] sq;
    d  = int'(t) - int'(c);
    sq = EW'(d * d);
    return (sq < e) ? sq : e;
  endfunction

  // Difference unit: acts every other clock, holds Q/Eout between actions.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_phase  <= 1'b0;
      sob_q    <= 1'b0;
      sob_eout <= '0;
    end else begin
      u_phase <= ~u_phase;
      if (u_phase) begin
        if (sob_start) begin
          if (!(mute_en && sob_target == mute_target)) begin
            sob_q    <= 1'b1;
            sob_eout <= unit_e(sob_center, sob_target, sob_e);
          end
        end else begin
          sob_q <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops expected results on score handshakes and expected targets on each new start.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] t;
    if (rst_n) begin
      if (score_valid && score_ready) begin
        chk("ready_in_done", win_ready, 0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_score");
        end else begin
          e = exp_q.pop_front();
          chk("score", score, e.score);
          chk("corner", corner, e.corner);
          chk("timeout_err", timeout_err, e.terr);
        end
      end
      if (sob_start && !start_prev) begin
        if (tgt_q.size() == 0) begin
          fail_now("unexpected_start");
        end else begin
          t = tgt_q.pop_front();
          chk("target", sob_target, t);
          chk("q_low_at_start", sob_q, 0);
        end
      end
    end
    start_prev = sob_start;
  end

  task automatic pack(input logic [7:0] p[9]);
    for (int k = 0; k < 9; k++) win_pix[8*k +: 8] = p[k];
  endtask

  // Leaves win_valid high so consecutive calls stream windows back to back.
  task automatic send_window(input logic [7:0] p[9], input logic [EW-1:0] thr_v,
                             input logic [EW-1:0] es, input logic ec, input logic et,
                             input int ntg, input bit exp_en);
    exp_t e;
    int n;
    for (int i = 0; i < ntg; i++) tgt_q.push_back(p[NB[i]]);
    if (exp_en) begin
      e.score  = es;
      e.corner = ec;
      e.terr   = et;
      exp_q.push_back(e);
    end
    pack(p);
    thr       = thr_v;
    win_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!win_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!win_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tgt_q.size() != 0 || !win_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_win_ready"}, win_ready, 1);
    chk({tag, "_sob_start"}, sob_start, 0);
    chk({tag, "_sob_e"}, sob_e, 14'h3FFF);
    chk({tag, "_sob_center"}, sob_center, 0);
    chk({tag, "_sob_target"}, sob_target, 0);
    chk({tag, "_score_valid"}, score_valid, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_corner"}, corner, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    win_valid   = 1'b0;
    win_pix     = '0;
    thr         = '0;
    score_ready = 1'b1;
    mute_en     = 1'b0;
    mute_target = '0;
    start_prev  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flat window: every difference is zero.
    send_window(W_FLAT, 14'd0, 14'd0, 1'b0, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(400);

    // Min difference 3 -> score 9 > thr 5.
    send_window(W_S2, 14'd5, 14'd9, 1'b1, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(400);

    // Stalled result with the next window already offered.
    score_ready = 1'b0;
    send_window(W_S2, 14'd5, 14'd9, 1'b1, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    n = 0;
    while (!score_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!score_valid) fail_now("stall_valid_timeout");
    pack(W_FLAT);
    thr       = 14'd0;
    win_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("stall_score", score, 9);
      chk("stall_corner", corner, 1);
      chk("stall_valid", score_valid, 1);
      chk("stall_win_ready", win_ready, 0);
    end
    @(posedge clk);
    #1;
    score_ready = 1'b1;
    send_window(W_FLAT, 14'd0, 14'd0, 1'b0, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(400);

    // Unit never answers pair 3: abort after 16 clocks in ISSUE.
    mute_en     = 1'b1;
    mute_target = 8'd130;
    send_window(W_S2, 14'd5, 14'h3FFF, 1'b0, 1'b1, 4, 1'b1);
    win_valid = 1'b0;
    n = 0;
    while (!(sob_start && sob_target == 8'd130) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(sob_start && sob_target == 8'd130)) fail_now("mute_pair_not_seen");
    n = 0;
    while (!score_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", n, 16);
    wait_drain(400);
    mute_en = 1'b0;
    send_window(W_FLAT, 14'd0, 14'd0, 1'b0, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(400);

    // Reset during pair 5: no score for the dropped window.
    send_window(W_S2, 14'd5, 14'd0, 1'b0, 1'b0, 6, 1'b0);
    win_valid = 1'b0;
    n = 0;
    while (!(sob_start && sob_target == 8'd150) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(sob_start && sob_target == 8'd150)) fail_now("pair5_not_seen");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_window(W_S2, 14'd5, 14'd9, 1'b1, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(400);

    // Back-to-back windows, including squared-difference truncation and thr equality.
    send_window(W_A, 14'd20, 14'd25, 1'b1, 1'b0, 8, 1'b1);
    send_window(W_B, 14'd7232, 14'd7232, 1'b0, 1'b0, 8, 1'b1);
    send_window(W_C, 14'd15872, 14'd15873, 1'b1, 1'b0, 8, 1'b1);
    win_valid = 1'b0;
    wait_drain(1000);

    chk("targets_left", tgt_q.size(), 0);
    chk("scores_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
